// File: rtl/rx_burst_sequencer.sv
// Timed RX burst controller: queues host burst commands, gates DSP run at VITA time,
// frames samples with sof/eof (1-cycle strobe_in -> valid_out), and flags late/overflow/broken-chain errors.

module rx_cmd_fifo #(
  parameter int W  = 94,
  parameter int AW = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);
  localparam logic [AW:0] ONE = 1;

  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module rx_burst_sequencer #(
  parameter logic [7:0] BASE      = 8'd176,
  parameter int         CMD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] vita_time,
  input  logic [31:0] sample_in,
  input  logic        strobe_in,
  input  logic        ready_in,
  output logic        run,
  output logic [31:0] sample_out,
  output logic        valid_out,
  output logic        sof,
  output logic        eof,
  output logic        err_stb,
  output logic [1:0]  err_code,
  output logic        cmd_full,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RUN, ERR} state_t;

  localparam logic [1:0] E_LATE  = 2'd1;
  localparam logic [1:0] E_OVF   = 2'd2;
  localparam logic [1:0] E_CHAIN = 2'd3;
  localparam int         CMD_W   = 94;

  state_t      state;
  logic        pend_imm;
  logic        pend_chain;
  logic [27:0] pend_num;
  logic [31:0] time_hi_r;
  logic        cmd_chain;
  logic [63:0] cmd_time;
  logic [27:0] count;
  logic        first;

  logic             wr_word;
  logic             stop_req;
  logic             push;
  logic             pop;
  logic             flush;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_dat;
  logic             f_imm;
  logic             f_chain;
  logic [27:0]      f_num;
  logic [63:0]      f_time;
  logic             last_smp;
  logic             unused_bits;

  assign wr_word     = set_stb && (set_addr == BASE);
  assign stop_req    = wr_word && set_data[29];
  assign push        = set_stb && (set_addr == BASE + 8'd2);
  assign unused_bits = set_data[28];

  assign f_imm   = fifo_dat[93];
  assign f_chain = fifo_dat[92];
  assign f_num   = fifo_dat[91:64];
  assign f_time  = fifo_dat[63:0];

  // accepted sample that closes the current command
  assign last_smp = (state == RUN) && strobe_in && ready_in && (count == 28'd1);

  assign pop   = !stop_req && !fifo_empty &&
                 ((state == IDLE) || (last_smp && cmd_chain));
  assign flush = stop_req || (state == ERR);

  rx_cmd_fifo #(.W(CMD_W), .AW(CMD_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .push_dat ({pend_imm, pend_chain, pend_num, time_hi_r, set_data}),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .empty    (fifo_empty),
    .full     (cmd_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      run        <= 1'b0;
      valid_out  <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      err_stb    <= 1'b0;
      err_code   <= 2'd0;
      sample_out <= 32'd0;
      pend_imm   <= 1'b0;
      pend_chain <= 1'b0;
      pend_num   <= 28'd0;
      time_hi_r  <= 32'd0;
      cmd_chain  <= 1'b0;
      cmd_time   <= 64'd0;
      count      <= 28'd0;
      first      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      sof       <= 1'b0;
      eof       <= 1'b0;
      err_stb   <= 1'b0;

      if (wr_word && !set_data[29]) begin
        pend_imm   <= set_data[31];
        pend_chain <= set_data[30];
        pend_num   <= set_data[27:0];
      end
      if (set_stb && (set_addr == BASE + 8'd1)) time_hi_r <= set_data;

      if (stop_req) begin
        state <= IDLE;
        busy  <= 1'b0;
        run   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!fifo_empty) begin
              cmd_chain <= f_chain;
              cmd_time  <= f_time;
              count     <= f_num;
              first     <= 1'b1;
              busy      <= 1'b1;
              if (f_imm) begin
                state <= RUN;
                run   <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end
          end
          WAIT: begin
            if (vita_time == cmd_time) begin
              state <= RUN;
              run   <= 1'b1;
            end else if (vita_time > cmd_time) begin
              state    <= ERR;
              err_stb  <= 1'b1;
              err_code <= E_LATE;
            end
          end
          RUN: begin
            if (strobe_in && !ready_in) begin
              state    <= ERR;
              run      <= 1'b0;
              err_stb  <= 1'b1;
              err_code <= E_OVF;
            end else if (strobe_in) begin
              sample_out <= sample_in;
              valid_out  <= 1'b1;
              sof        <= first;
              eof        <= (count == 28'd1);
              first      <= 1'b0;
              // a zero count wraps here, which is what gives num_samples=0 its 2^28 length
              count      <= count - 28'd1;
              if (count == 28'd1) begin
                if (!cmd_chain) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  run   <= 1'b0;
                end else if (!fifo_empty) begin
                  cmd_chain <= f_chain;
                  cmd_time  <= f_time;
                  count     <= f_num;
                  first     <= 1'b1;
                end else begin
                  state    <= ERR;
                  run      <= 1'b0;
                  err_stb  <= 1'b1;
                  err_code <= E_CHAIN;
                end
              end
            end
          end
          ERR: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            run   <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_burst_sequencer.sv
// Directed bench for rx_burst_sequencer: one task per scenario, hand-computed expectations.

module tb_rx_burst_sequencer;
  localparam logic [7:0] BASE = 8'd176;

  logic        clk;
  logic        rst;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [63:0] vita_time;
  logic [31:0] sample_in;
  logic        strobe_in;
  logic        ready_in;
  logic        run;
  logic [31:0] sample_out;
  logic        valid_out;
  logic        sof;
  logic        eof;
  logic        err_stb;
  logic [1:0]  err_code;
  logic        cmd_full;
  logic        busy;

  int checks;
  int errors;

  int          n_valid;
  int          n_eof;
  int          n_err;
  int          n_run;
  int          run_rise;
  logic        prev_run;
  logic [1:0]  last_code;
  logic [15:0] sof_mask;
  logic [15:0] eof_mask;
  logic [31:0] smp [16];

  rx_burst_sequencer #(.BASE(BASE), .CMD_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .vita_time  (vita_time),
    .sample_in  (sample_in),
    .strobe_in  (strobe_in),
    .ready_in   (ready_in),
    .run        (run),
    .sample_out (sample_out),
    .valid_out  (valid_out),
    .sof        (sof),
    .eof        (eof),
    .err_stb    (err_stb),
    .err_code   (err_code),
    .cmd_full   (cmd_full),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    vita_time = vita_time + 64'd1;
    if (valid_out) begin
      if (n_valid < 16) begin
        smp[n_valid]      = sample_out;
        sof_mask[n_valid] = sof;
        eof_mask[n_valid] = eof;
      end
      n_valid++;
    end
    if (eof) n_eof++;
    if (err_stb) begin
      n_err++;
      last_code = err_code;
    end
    if (run) n_run++;
    if (run && !prev_run) run_rise++;
    prev_run = run;
  endtask

  task automatic clr_mon();
    n_valid   = 0;
    n_eof     = 0;
    n_err     = 0;
    n_run     = 0;
    run_rise  = 0;
    prev_run  = run;
    last_code = 2'd0;
    sof_mask  = '0;
    eof_mask  = '0;
    for (int i = 0; i < 16; i++) smp[i] = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    tick();
    set_stb  = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] word, input logic [63:0] t);
    wr(BASE, word);
    wr(BASE + 8'd1, t[63:32]);
    wr(BASE + 8'd2, t[31:0]);
  endtask

  // strobe on every 'period'-th cycle for 'len' cycles, ready held high
  task automatic strobe_run(input int len, input int period, input logic [31:0] seed);
    for (int i = 0; i < len; i++) begin
      strobe_in = (i % period == 0);
      sample_in = seed + 32'(i);
      tick();
    end
    strobe_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    if (run !== 1'b0) begin errors++; $display("FAIL reset_run got %b exp 0", run); end
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    checks++;
    if ({sof, eof} !== 2'b00) begin errors++; $display("FAIL reset_sof_eof got %b exp 00", {sof, eof}); end
    checks++;
    if (err_stb !== 1'b0) begin errors++; $display("FAIL reset_err_stb got %b exp 0", err_stb); end
    checks++;
    if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code got %0d exp 0", err_code); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (sample_out !== 32'd0) begin errors++; $display("FAIL reset_sample got %h exp 0", sample_out); end
    checks++;
    if (cmd_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", cmd_full); end
    checks++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_immediate();
    clr_mon();
    push_cmd(32'h8000_0005, 64'd0);
    if (run !== 1'b0) begin errors++; $display("FAIL imm_run_at_push got %b exp 0", run); end
    checks++;
    for (int i = 0; i < 40; i++) begin
      strobe_in = (i % 4 == 0);
      sample_in = 32'h1000 + 32'(i);
      tick();
      if (i == 0) begin
        if (run !== 1'b1) begin errors++; $display("FAIL imm_run_rise got %b exp 1", run); end
        checks++;
      end
    end
    strobe_in = 1'b0;
    if (n_valid !== 5) begin errors++; $display("FAIL imm_valid_count got %0d exp 5", n_valid); end
    checks++;
    if (sof_mask !== 16'h0001) begin errors++; $display("FAIL imm_sof got %h exp 0001", sof_mask); end
    checks++;
    if (eof_mask !== 16'h0010) begin errors++; $display("FAIL imm_eof got %h exp 0010", eof_mask); end
    checks++;
    if (smp[0] !== 32'h1004) begin errors++; $display("FAIL imm_sample1 got %h exp 1004", smp[0]); end
    checks++;
    if (smp[4] !== 32'h1014) begin errors++; $display("FAIL imm_sample5 got %h exp 1014", smp[4]); end
    checks++;
    if ({run, busy} !== 2'b00) begin errors++; $display("FAIL imm_idle_after got %b exp 00", {run, busy}); end
    checks++;
    if (n_err !== 0) begin errors++; $display("FAIL imm_no_err got %0d exp 0", n_err); end
    checks++;
  endtask

  task automatic test_timed();
    logic [63:0] v;
    logic [63:0] rise_v;
    logic        seen;
    clr_mon();
    seen      = 1'b0;
    rise_v    = '0;
    vita_time = 64'd900;
    push_cmd(32'h0000_0003, 64'd1000);
    for (int i = 0; i < 130; i++) begin
      strobe_in = (i % 3 == 0);
      sample_in = 32'h2000 + 32'(i);
      v = vita_time;
      tick();
      if (run && !seen) begin
        seen   = 1'b1;
        rise_v = v;
      end
    end
    strobe_in = 1'b0;
    if (rise_v !== 64'd1000) begin errors++; $display("FAIL timed_rise_time got %0d exp 1000", rise_v); end
    checks++;
    if (n_valid !== 3) begin errors++; $display("FAIL timed_valid_count got %0d exp 3", n_valid); end
    checks++;
    if (eof_mask !== 16'h0004) begin errors++; $display("FAIL timed_eof got %h exp 0004", eof_mask); end
    checks++;
    if (n_err !== 0) begin errors++; $display("FAIL timed_no_err got %0d exp 0", n_err); end
    checks++;
    if (run !== 1'b0) begin errors++; $display("FAIL timed_run_after got %b exp 0", run); end
    checks++;
  endtask

  task automatic test_late();
    clr_mon();
    vita_time = 64'd800;
    push_cmd(32'h0000_0004, 64'd500);
    for (int i = 0; i < 8; i++) tick();
    if (n_err !== 1) begin errors++; $display("FAIL late_err_pulses got %0d exp 1", n_err); end
    checks++;
    if (last_code !== 2'd1) begin errors++; $display("FAIL late_code got %0d exp 1", last_code); end
    checks++;
    if (n_run !== 0) begin errors++; $display("FAIL late_run_cycles got %0d exp 0", n_run); end
    checks++;
    if ({busy, cmd_full} !== 2'b00) begin errors++; $display("FAIL late_idle got %b exp 00", {busy, cmd_full}); end
    checks++;
    if (err_code !== 2'd1) begin errors++; $display("FAIL late_code_held got %0d exp 1", err_code); end
    checks++;
  endtask

  task automatic test_chain();
    clr_mon();
    push_cmd(32'hC000_0002, 64'd0);
    push_cmd(32'h0000_0003, 64'd5);
    strobe_run(24, 3, 32'h3000);
    if (n_valid !== 5) begin errors++; $display("FAIL chain_valid_count got %0d exp 5", n_valid); end
    checks++;
    if (sof_mask !== 16'h0005) begin errors++; $display("FAIL chain_sof got %h exp 0005", sof_mask); end
    checks++;
    if (eof_mask !== 16'h0012) begin errors++; $display("FAIL chain_eof got %h exp 0012", eof_mask); end
    checks++;
    if (run_rise !== 1) begin errors++; $display("FAIL chain_run_gapless got %0d rises exp 1", run_rise); end
    checks++;
    if (n_err !== 0) begin errors++; $display("FAIL chain_no_err got %0d exp 0", n_err); end
    checks++;
    if (smp[2] !== 32'h3006) begin errors++; $display("FAIL chain_sample3 got %h exp 3006", smp[2]); end
    checks++;
  endtask

  task automatic test_broken_chain();
    clr_mon();
    push_cmd(32'hC000_0002, 64'd0);
    tick();
    strobe_run(12, 3, 32'h4000);
    if (n_valid !== 2) begin errors++; $display("FAIL broken_valid_count got %0d exp 2", n_valid); end
    checks++;
    if (eof_mask !== 16'h0002) begin errors++; $display("FAIL broken_eof got %h exp 0002", eof_mask); end
    checks++;
    if (n_err !== 1) begin errors++; $display("FAIL broken_err_pulses got %0d exp 1", n_err); end
    checks++;
    if (last_code !== 2'd3) begin errors++; $display("FAIL broken_code got %0d exp 3", last_code); end
    checks++;
    if ({run, busy} !== 2'b00) begin errors++; $display("FAIL broken_idle got %b exp 00", {run, busy}); end
    checks++;
  endtask

  task automatic test_overflow();
    clr_mon();
    push_cmd(32'h8000_0004, 64'd0);
    tick();
    for (int i = 0; i < 12; i++) begin
      strobe_in = (i % 3 == 0);
      ready_in  = ((i / 3) != 1);
      sample_in = 32'h5000 + 32'(i);
      tick();
    end
    strobe_in = 1'b0;
    ready_in  = 1'b1;
    if (n_valid !== 1) begin errors++; $display("FAIL ovf_valid_count got %0d exp 1", n_valid); end
    checks++;
    if (n_eof !== 0) begin errors++; $display("FAIL ovf_eof_count got %0d exp 0", n_eof); end
    checks++;
    if (n_err !== 1) begin errors++; $display("FAIL ovf_err_pulses got %0d exp 1", n_err); end
    checks++;
    if (last_code !== 2'd2) begin errors++; $display("FAIL ovf_code got %0d exp 2", last_code); end
    checks++;
    if (run !== 1'b0) begin errors++; $display("FAIL ovf_run_after got %b exp 0", run); end
    checks++;
  endtask

  task automatic test_full_and_stop();
    clr_mon();
    // first command parks in WAIT, the next four fill the queue
    for (int k = 0; k < 6; k++) begin
      push_cmd(32'h0000_0001, 64'h0000_0001_0000_0000);
      if (k == 3) begin
        if (cmd_full !== 1'b0) begin errors++; $display("FAIL full_early got %b exp 0", cmd_full); end
        checks++;
      end
      if (k == 4) begin
        if (cmd_full !== 1'b1) begin errors++; $display("FAIL full_set got %b exp 1", cmd_full); end
        checks++;
      end
    end
    if ({cmd_full, busy} !== 2'b11) begin errors++; $display("FAIL full_hold got %b exp 11", {cmd_full, busy}); end
    checks++;
    wr(BASE, 32'h2000_0000);
    if ({cmd_full, busy, run} !== 3'b000) begin errors++; $display("FAIL stop_flush got %b exp 000", {cmd_full, busy, run}); end
    checks++;
    for (int i = 0; i < 4; i++) tick();
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_stays_idle got %b exp 0", busy); end
    checks++;
    if (n_err !== 0) begin errors++; $display("FAIL stop_no_err got %0d exp 0", n_err); end
    checks++;

    clr_mon();
    push_cmd(32'h8000_000A, 64'd0);
    tick();
    strobe_run(3, 3, 32'h6000);
    if (run !== 1'b1) begin errors++; $display("FAIL stop_run_before got %b exp 1", run); end
    checks++;
    wr(BASE, 32'h2000_0000);
    if ({run, busy} !== 2'b00) begin errors++; $display("FAIL stop_run_next got %b exp 00", {run, busy}); end
    checks++;
    for (int i = 0; i < 3; i++) tick();
    if ({n_eof, n_err} !== {32'd0, 32'd0}) begin errors++; $display("FAIL stop_no_eof_err got eof %0d err %0d exp 0 0", n_eof, n_err); end
    checks++;
    if (n_valid !== 1) begin errors++; $display("FAIL stop_valid_count got %0d exp 1", n_valid); end
    checks++;
  endtask

  task automatic test_reset_mid_burst();
    clr_mon();
    push_cmd(32'h8000_0008, 64'd0);
    tick();
    strobe_run(6, 3, 32'h7000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    if ({run, busy, valid_out} !== 3'b000) begin errors++; $display("FAIL rstmid_idle got %b exp 000", {run, busy, valid_out}); end
    checks++;
    if (n_valid !== 2) begin errors++; $display("FAIL rstmid_valid_count got %0d exp 2", n_valid); end
    checks++;
    if (n_eof !== 0) begin errors++; $display("FAIL rstmid_eof got %0d exp 0", n_eof); end
    checks++;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    set_stb   = 1'b0;
    set_addr  = 8'd0;
    set_data  = 32'd0;
    vita_time = 64'd0;
    sample_in = 32'd0;
    strobe_in = 1'b0;
    ready_in  = 1'b1;
    prev_run  = 1'b0;
    clr_mon();

    test_reset();
    test_immediate();
    test_timed();
    test_late();
    test_chain();
    test_broken_chain();
    test_overflow();
    test_full_and_stop();
    test_reset_mid_burst();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
